// File: rtl/seq_pattern_detector_if.sv
// rtl/seq_pattern_detector_if.sv - stimulus and indicator signals of the serial pattern detector
interface seq_pattern_detector_if #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 8
);
   logic             data;
   logic             trig;
   logic             clear;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic [PAT_W-1:0] pat_mask;
   logic             overlap;
   logic [PAT_W-1:0] led;
   logic             on_led;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output data, trig, clear, pat_load, pat_in, pat_mask, overlap,
      input  led, on_led, match_cnt
   );

   modport slave (
      input  data, trig, clear, pat_load, pat_in, pat_mask, overlap,
      output led, on_led, match_cnt
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial pattern detector with maskable loadable pattern, stretched match LED and saturating counter
module seq_pattern_detector #(
   parameter int               PAT_W    = 5,
   parameter logic [PAT_W-1:0] PAT_RST  = 5'b10110,
   parameter int               HOLD_CYC = 4,
   parameter int               CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   seq_pattern_detector_if.slave bus
);
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam int HOLD_W = $clog2(HOLD_CYC + 1);

   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_ARMED = 1'b1;

   logic              trig_q;
   logic [PAT_W-1:0]  hist_q,  hist_d;
   logic [PAT_W-1:0]  pat_q,   pat_d;
   logic [PAT_W-1:0]  mask_q,  mask_d;
   logic [0:0]        state_q, state_d;
   logic [FILL_W-1:0] fill_q,  fill_d;
   logic [HOLD_W-1:0] hold_q,  hold_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic             accept;
   logic [PAT_W-1:0] hist_shift;
   logic             last_fill;
   logic             compare;
   logic             hit;

   assign accept     = bus.trig & ~trig_q;
   assign hist_shift = {hist_q[PAT_W-2:0], bus.data};
   assign last_fill  = (fill_q == FILL_W'(PAT_W - 1));
   // The accept that completes the first full history is already compared.
   assign compare    = accept & ((state_q == ST_ARMED) | last_fill);
   assign hit        = compare & (((hist_shift ^ pat_q) & mask_q) == '0);

   always_comb begin
      hist_d  = hist_q;
      pat_d   = pat_q;
      mask_d  = mask_q;
      state_d = state_q;
      fill_d  = fill_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;

      if (bus.clear) begin
         hist_d  = '0;
         state_d = ST_FILL;
         fill_d  = '0;
         hold_d  = '0;
         cnt_d   = '0;
      end else begin
         if (accept) begin
            hist_d = hist_shift;
            if (state_q == ST_FILL) begin
               fill_d = fill_q + FILL_W'(1);
               if (last_fill) begin
                  state_d = ST_ARMED;
               end
            end
         end
         if (hit) begin
            hold_d = HOLD_W'(HOLD_CYC);
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Non-overlapping mode restarts the fill; led keeps the matching history.
            if (!bus.overlap) begin
               state_d = ST_FILL;
               fill_d  = '0;
            end
         end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
         end
      end

      if (bus.pat_load) begin
         pat_d  = bus.pat_in;
         mask_d = bus.pat_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trig_q  <= 1'b1;
         hist_q  <= '0;
         pat_q   <= PAT_RST;
         mask_q  <= '1;
         state_q <= ST_FILL;
         fill_q  <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         trig_q  <= bus.trig;
         hist_q  <= hist_d;
         pat_q   <= pat_d;
         mask_q  <= mask_d;
         state_q <= state_d;
         fill_q  <= fill_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.led       = hist_q;
   assign bus.on_led    = (hold_q != '0);
   assign bus.match_cnt = cnt_q;
endmodule
